// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// The master side (controller) receives IR fields and status and drives the datapath controls.
interface multicycle_ctrl_if;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned STATE_W = 4;

  // Datapath status and instruction fields
  logic [OP_W-1:0]    op;
  logic [FUNC_W-1:0]  func;
  logic               zero;
  logic               mem_ready;

  // Datapath controls
  logic               pc_en;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [SEL_W-1:0]   ALUSrcB;
  logic [SEL_W-1:0]   PCSource;
  logic [ALUOP_W-1:0] ALU_op;
  logic [STATE_W-1:0] state;
  logic               instr_done;
  logic               illegal;

  modport master (
    input  op, func, zero, mem_ready,
    output pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSource, ALU_op, state, instr_done, illegal
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, PCSource, ALU_op, state, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: sequences fetch, decode and per-class execute states.
// Controls are decoded from the current state (some gated by mem_ready/zero) and forced low during reset.
module multicycle_ctrl (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXE  = 4'd6,
    RTWB   = 4'd7,
    BEQ    = 4'd8,
    LUIEX  = 4'd9,
    IMMWB  = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic               pc_en;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   pc_source;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_done;
    logic               illegal;
  } ctrl_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNC_W-1:0] FN_XOR = 6'b100110;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b101;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_LUI = 3'b110;

  localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctl;

  function automatic logic rtype_legal(input logic [FUNC_W-1:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] rtype_alu_op(input logic [FUNC_W-1:0] f);
    case (f)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state and control decode; op/func are only consulted once IR has been loaded.
  always_comb begin
    state_d = state_q;
    ctl     = '0;

    case (state_q)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.ir_write  = bus.mem_ready;
        ctl.pc_en     = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        ctl.alu_src_b = SRCB_IMMSH;
        ctl.alu_op    = ALU_ADD;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = rtype_legal(bus.func) ? RTEXE : TRAP;
          OP_BEQ:       state_d = BEQ;
          OP_LUI:       state_d = LUIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_ADD;
        state_d       = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        ctl.mem_write  = 1'b1;
        ctl.iord       = 1'b1;
        ctl.instr_done = bus.mem_ready;
        if (bus.mem_ready) state_d = FETCH;
      end
      RTEXE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.alu_op    = rtype_alu_op(bus.func);
        state_d       = RTWB;
      end
      RTWB: begin
        ctl.reg_dst    = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = FETCH;
      end
      BEQ: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_src_b  = SRCB_REG;
        ctl.alu_op     = ALU_SUB;
        ctl.pc_source  = PCSRC_ALUOUT;
        ctl.pc_en      = bus.zero;
        ctl.instr_done = 1'b1;
        state_d        = FETCH;
      end
      LUIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_LUI;
        state_d       = IMMWB;
      end
      IMMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = FETCH;
      end
      JUMP: begin
        ctl.pc_source  = PCSRC_JUMP;
        ctl.pc_en      = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = FETCH;
      end
      TRAP: begin
        ctl.illegal = 1'b1;
        state_d     = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase

    // Reset must abort a pending access without waiting for a clock edge.
    if (rst) ctl = '0;
  end

  assign bus.pc_en      = ctl.pc_en;
  assign bus.IorD       = ctl.iord;
  assign bus.MemRead    = ctl.mem_read;
  assign bus.MemWrite   = ctl.mem_write;
  assign bus.IRWrite    = ctl.ir_write;
  assign bus.RegDst     = ctl.reg_dst;
  assign bus.MemtoReg   = ctl.mem_to_reg;
  assign bus.RegWrite   = ctl.reg_write;
  assign bus.ALUSrcA    = ctl.alu_src_a;
  assign bus.ALUSrcB    = ctl.alu_src_b;
  assign bus.PCSource   = ctl.pc_source;
  assign bus.ALU_op     = ctl.alu_op;
  assign bus.instr_done = ctl.instr_done;
  assign bus.illegal    = ctl.illegal;
  assign bus.state      = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle
// and compares state plus the full control vector against hand-built expectations.
module tb_multicycle_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector layout:
  // {pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
  //  ALUSrcA, ALUSrcB[1:0], PCSource[1:0], ALU_op[2:0], instr_done, illegal}
  localparam logic [17:0] PCE      = 18'h20000;
  localparam logic [17:0] IORD     = 18'h10000;
  localparam logic [17:0] MRD      = 18'h08000;
  localparam logic [17:0] MWR      = 18'h04000;
  localparam logic [17:0] IRW      = 18'h02000;
  localparam logic [17:0] RDST     = 18'h01000;
  localparam logic [17:0] M2R      = 18'h00800;
  localparam logic [17:0] RW       = 18'h00400;
  localparam logic [17:0] ASA      = 18'h00200;
  localparam logic [17:0] ASB_4    = 18'h00080;
  localparam logic [17:0] ASB_IMM  = 18'h00100;
  localparam logic [17:0] ASB_SH   = 18'h00180;
  localparam logic [17:0] PCS_AO   = 18'h00020;
  localparam logic [17:0] PCS_J    = 18'h00040;
  localparam logic [17:0] AOP_AND  = 18'h00004;
  localparam logic [17:0] AOP_XOR  = 18'h00008;
  localparam logic [17:0] AOP_SUB  = 18'h00010;
  localparam logic [17:0] AOP_OR   = 18'h00014;
  localparam logic [17:0] AOP_LUI  = 18'h00018;
  localparam logic [17:0] DONE     = 18'h00002;
  localparam logic [17:0] ILL      = 18'h00001;

  localparam logic [17:0] C_FETCH  = PCE | MRD | IRW | ASB_4;
  localparam logic [17:0] C_FSTALL = MRD | ASB_4;
  localparam logic [17:0] C_DEC    = ASB_SH;
  localparam logic [17:0] C_MADR   = ASA | ASB_IMM;
  localparam logic [17:0] C_MRD    = IORD | MRD;
  localparam logic [17:0] C_MWB    = RW | M2R | DONE;
  localparam logic [17:0] C_MWR0   = IORD | MWR;
  localparam logic [17:0] C_MWR1   = IORD | MWR | DONE;
  localparam logic [17:0] C_RTWB   = RDST | RW | DONE;
  localparam logic [17:0] C_BEQ1   = PCE | ASA | AOP_SUB | PCS_AO | DONE;
  localparam logic [17:0] C_BEQ0   = ASA | AOP_SUB | PCS_AO | DONE;
  localparam logic [17:0] C_LUI    = ASA | ASB_IMM | AOP_LUI;
  localparam logic [17:0] C_IMMWB  = RW | DONE;
  localparam logic [17:0] C_JMP    = PCE | PCS_J | DONE;
  localparam logic [17:0] C_TRAP   = ILL;

  function automatic logic [17:0] ctl_vec();
    return {bus.pc_en, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.PCSource, bus.ALU_op, bus.instr_done, bus.illegal};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after an active edge with inputs already set; checks this cycle, then advances.
  task automatic expect_cycle(input string tag, input logic [3:0] st, input logic [17:0] c);
    #1;
    check_eq({tag, "_state"}, 32'(bus.state), 32'(st));
    check_eq({tag, "_ctl"}, 32'(ctl_vec()), 32'(c));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq({tag, "_rst_state"}, 32'(bus.state), 32'd0);
    check_eq({tag, "_rst_ctl"}, 32'(ctl_vec()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [5:0]  rt_func [4];
  logic [17:0] rt_aop  [4];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.op = 6'b000000;
    bus.func = 6'b000000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    rt_func[0] = 6'b100010; rt_aop[0] = AOP_SUB;
    rt_func[1] = 6'b100100; rt_aop[1] = AOP_AND;
    rt_func[2] = 6'b100101; rt_aop[2] = AOP_OR;
    rt_func[3] = 6'b100110; rt_aop[3] = AOP_XOR;
    #1;
    do_reset("init");

    // add
    bus.op = 6'b000000; bus.func = 6'b100000;
    expect_cycle("add_f", 4'd0, C_FETCH);
    expect_cycle("add_d", 4'd1, C_DEC);
    expect_cycle("add_x", 4'd6, ASA);
    expect_cycle("add_wb", 4'd7, C_RTWB);

    // remaining R-type ALU encodings
    for (int i = 0; i < 4; i++) begin
      bus.func = rt_func[i];
      expect_cycle("rt_f", 4'd0, C_FETCH);
      expect_cycle("rt_d", 4'd1, C_DEC);
      expect_cycle("rt_x", 4'd6, ASA | rt_aop[i]);
      expect_cycle("rt_wb", 4'd7, C_RTWB);
    end

    // lw with two memory wait cycles in MEMRD
    bus.op = 6'b100011; bus.mem_ready = 1'b1;
    expect_cycle("lw_f", 4'd0, C_FETCH);
    expect_cycle("lw_d", 4'd1, C_DEC);
    expect_cycle("lw_a", 4'd2, C_MADR);
    bus.mem_ready = 1'b0;
    expect_cycle("lw_r0", 4'd3, C_MRD);
    expect_cycle("lw_r1", 4'd3, C_MRD);
    bus.mem_ready = 1'b1;
    expect_cycle("lw_r2", 4'd3, C_MRD);
    expect_cycle("lw_wb", 4'd4, C_MWB);

    // sw with one FETCH wait and one MEMWR wait
    bus.op = 6'b101011; bus.mem_ready = 1'b0;
    expect_cycle("sw_fs", 4'd0, C_FSTALL);
    bus.mem_ready = 1'b1;
    expect_cycle("sw_f", 4'd0, C_FETCH);
    expect_cycle("sw_d", 4'd1, C_DEC);
    expect_cycle("sw_a", 4'd2, C_MADR);
    bus.mem_ready = 1'b0;
    expect_cycle("sw_w0", 4'd5, C_MWR0);
    bus.mem_ready = 1'b1;
    expect_cycle("sw_w1", 4'd5, C_MWR1);

    // beq taken and not taken
    bus.op = 6'b000100; bus.zero = 1'b1;
    expect_cycle("beq1_f", 4'd0, C_FETCH);
    expect_cycle("beq1_d", 4'd1, C_DEC);
    expect_cycle("beq1_x", 4'd8, C_BEQ1);
    bus.zero = 1'b0;
    expect_cycle("beq0_f", 4'd0, C_FETCH);
    expect_cycle("beq0_d", 4'd1, C_DEC);
    expect_cycle("beq0_x", 4'd8, C_BEQ0);

    // lui
    bus.op = 6'b001111;
    expect_cycle("lui_f", 4'd0, C_FETCH);
    expect_cycle("lui_d", 4'd1, C_DEC);
    expect_cycle("lui_x", 4'd9, C_LUI);
    expect_cycle("lui_wb", 4'd10, C_IMMWB);

    // j
    bus.op = 6'b000010;
    expect_cycle("j_f", 4'd0, C_FETCH);
    expect_cycle("j_d", 4'd1, C_DEC);
    expect_cycle("j_x", 4'd11, C_JMP);

    // R-type with unsupported func traps
    bus.op = 6'b000000; bus.func = 6'b000000;
    expect_cycle("badfn_f", 4'd0, C_FETCH);
    expect_cycle("badfn_d", 4'd1, C_DEC);
    expect_cycle("badfn_t", 4'd12, C_TRAP);
    do_reset("badfn");

    // illegal opcode: TRAP holds regardless of mem_ready until reset
    bus.op = 6'b111111;
    expect_cycle("badop_f", 4'd0, C_FETCH);
    expect_cycle("badop_d", 4'd1, C_DEC);
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = i[0];
      expect_cycle("badop_t", 4'd12, C_TRAP);
    end
    bus.mem_ready = 1'b1;
    do_reset("badop");

    // reset during a stalled store drops MemWrite immediately
    bus.op = 6'b101011;
    expect_cycle("rsw_f", 4'd0, C_FETCH);
    expect_cycle("rsw_d", 4'd1, C_DEC);
    expect_cycle("rsw_a", 4'd2, C_MADR);
    bus.mem_ready = 1'b0;
    expect_cycle("rsw_w0", 4'd5, C_MWR0);
    #1;
    check_eq("rsw_hold_mwr", 32'(bus.MemWrite), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rsw_async_mwr", 32'(bus.MemWrite), 32'd0);
    check_eq("rsw_async_state", 32'(bus.state), 32'd0);
    check_eq("rsw_async_ctl", 32'(ctl_vec()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    expect_cycle("rsw_post", 4'd0, C_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 op  in  6  IR[31:26].
REQ-005 func  in  6  IR[5:0].
REQ-006 zero  in  1  ALU zero flag.
REQ-007 mem_ready  in  1  memory completes current access this cycle.
REQ-008 pc_en  out  1  PC load enable.
REQ-009 IorD  out  1  memory address select: 0 PC, 1 ALUOut.
REQ-010 MemRead / MemWrite  out  1 each  memory strobes.
REQ-011 IRWrite  out  1  IR load enable.
REQ-012 RegDst / MemtoReg / RegWrite  out  1 each  register-file write controls.
REQ-013 ALUSrcA  out  1  0 PC, 1 reg A.
REQ-014 ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-015 PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-016 ALU_op  out  3  000 add, 100 sub, 001 and, 101 or, 010 xor, 110 lui.
REQ-017 state  out  4  current state encoding (debug).
REQ-018 instr_done  out  1  one-cycle pulse in final cycle of each instruction.
REQ-019 illegal  out  1  high while in TRAP.

Function
REQ-020 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BEQ=8, LUIEX=9, IMMWB=10, JUMP=11, TRAP=12; codes 13-15 SHALL go to TRAP.
REQ-021 Every output not listed for a state SHALL be 0 in that state.
REQ-022 FETCH: MemRead=1, IorD=0, ALUSrcB=01, ALU_op=000, PCSource=00; IRWrite=pc_en=mem_ready; mem_ready=1 -> DECODE, else stay.
REQ-023 DECODE: ALUSrcB=11, ALU_op=000; next: op 100011/101011 -> MEMADR; 000000 with func in {100000,100010,100100,100101,100110} -> RTEXE; 000100 -> BEQ; 001111 -> LUIEX; 000010 -> JUMP; any other op/func -> TRAP.
REQ-024 MEMADR: ALUSrcA=1, ALUSrcB=10, ALU_op=000; op 100011 -> MEMRD, else -> MEMWR.
REQ-025 MEMRD: MemRead=1, IorD=1; mem_ready=1 -> MEMWB, else stay.
REQ-026 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; -> FETCH.
REQ-027 MEMWR: MemWrite=1, IorD=1; instr_done=mem_ready; mem_ready=1 -> FETCH, else stay.
REQ-028 RTEXE: ALUSrcA=1, ALUSrcB=00, ALU_op by func (add 000, sub 100, and 001, or 101, xor 010); -> RTWB.
REQ-029 RTWB: RegDst=1, RegWrite=1, instr_done=1; -> FETCH.
REQ-030 BEQ: ALUSrcA=1, ALUSrcB=00, ALU_op=100, PCSource=01, pc_en=zero (combinational), instr_done=1; -> FETCH.
REQ-031 LUIEX: ALUSrcA=1, ALUSrcB=10, ALU_op=110; -> IMMWB. IMMWB: RegWrite=1, RegDst=0, instr_done=1; -> FETCH.
REQ-032 JUMP: PCSource=10, pc_en=1, instr_done=1; -> FETCH.
REQ-033 TRAP: illegal=1, all enables 0; SHALL stay until rst.
REQ-034 With mem_ready tied 1, cycle counts SHALL be lw 5, sw 4, R-type 4, lui 4, beq 3, j 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
REQ-035 op/func SHALL be used only from DECODE onward (IR stable).

Reset
REQ-036 rst=1 SHALL asynchronously force state=FETCH and all outputs 0 while asserted, aborting any pending access (MemWrite drops without waiting for a clock).
REQ-037 First cycle after rst deassertion SHALL present FETCH outputs.

Verification
REQ-038 add (op 0, func 100000), mem_ready=1 -> states 0,1,6,7; RTWB: RegDst=1, RegWrite=1, instr_done=1.
REQ-039 lw with mem_ready=0 for 2 cycles in MEMRD -> 0,1,2,3,3,3,4; total 7 cycles; MemtoReg=1 in MEMWB only.
REQ-040 beq with zero=1 -> pc_en=1, PCSource=01 in BEQ; zero=0 -> pc_en=0; both 3 cycles.
REQ-041 op 111111 -> DECODE then TRAP; illegal=1, no enables for 10 cycles; rst -> FETCH.
REQ-042 rst asserted mid-MEMWR (mem_ready=0) -> MemWrite=0 immediately, state=0.
REQ-043 R-type func 000000 -> TRAP after DECODE.
